// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave mapping a 32-bit little-endian region onto an 8-bit sync SRAM; one SRAM byte access per cycle.
// Data phase: write N cycles, read N+1 cycles (N = bytes); HREADYOUT stalls the bus, misaligned/oversized -> 2-cycle ERROR.
module ahb_sram_bridge #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic                  SRAM_CEN,
  output logic                  SRAM_WEN,
  output logic [ADDR_WIDTH-1:0] SRAM_A,
  output logic [7:0]            SRAM_D,
  input  logic [7:0]            SRAM_Q,
  output logic                  SRAM_OEN
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WRITE, ST_READ, ST_RDONE, ST_ERR1, ST_ERR2
  } state_t;

  state_t     state;
  logic [1:0] cnt;
  logic [1:0] n_m1;
  logic [1:0] lane;
  logic [1:0] byte_sel;
  logic [1:0] size_m1;
  logic       accept;
  logic       illegal;
  logic       last_cycle;
  logic       unused_bits;

  assign unused_bits = ^{HTRANS[0], HADDR[31:ADDR_WIDTH]};

  assign accept   = HSEL & HREADY & HTRANS[1];
  assign illegal  = (HSIZE > 3'd2) | ((HSIZE == 3'd1) & HADDR[0]) | ((HSIZE == 3'd2) & (|HADDR[1:0]));
  assign byte_sel = lane + cnt;
  assign SRAM_D   = HWDATA[{byte_sel, 3'b000} +: 8];
  assign SRAM_OEN = 1'b0;

  // Cycles in which the bus may present the next address phase.
  assign last_cycle = (state == ST_IDLE) | (state == ST_RDONE) | (state == ST_ERR2) |
                      ((state == ST_WRITE) & (cnt == n_m1));

  always_comb begin
    size_m1 = 2'd3;
    case (HSIZE)
      3'd0:    size_m1 = 2'd0;
      3'd1:    size_m1 = 2'd1;
      default: size_m1 = 2'd3;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      cnt       <= 2'd0;
      n_m1      <= 2'd0;
      lane      <= 2'd0;
      HRDATA    <= 32'd0;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      SRAM_CEN  <= 1'b1;
      SRAM_WEN  <= 1'b1;
      SRAM_A    <= '0;
    end else if (last_cycle) begin
      cnt <= 2'd0;
      if (accept && illegal) begin
        state     <= ST_ERR1;
        HREADYOUT <= 1'b0;
        HRESP     <= 1'b1;
        SRAM_CEN  <= 1'b1;
        SRAM_WEN  <= 1'b1;
      end else if (accept) begin
        state     <= HWRITE ? ST_WRITE : ST_READ;
        n_m1      <= size_m1;
        lane      <= HADDR[1:0];
        SRAM_A    <= HADDR[ADDR_WIDTH-1:0];
        SRAM_CEN  <= 1'b0;
        SRAM_WEN  <= ~HWRITE;
        HREADYOUT <= HWRITE & (HSIZE == 3'd0);
        HRESP     <= 1'b0;
        if (!HWRITE) begin
          HRDATA <= 32'd0;
        end
      end else begin
        state     <= ST_IDLE;
        HREADYOUT <= 1'b1;
        HRESP     <= 1'b0;
        SRAM_CEN  <= 1'b1;
        SRAM_WEN  <= 1'b1;
      end
    end else begin
      case (state)
        ST_WRITE: begin
          cnt       <= cnt + 2'd1;
          SRAM_A    <= SRAM_A + ADDR_WIDTH'(1);
          HREADYOUT <= ((cnt + 2'd1) == n_m1);
        end
        ST_READ: begin
          // SRAM_Q for this cycle's access became valid at the preceding negedge.
          HRDATA[{byte_sel, 3'b000} +: 8] <= SRAM_Q;
          if (cnt == n_m1) begin
            state     <= ST_RDONE;
            HREADYOUT <= 1'b1;
            SRAM_CEN  <= 1'b1;
            SRAM_WEN  <= 1'b1;
          end else begin
            cnt    <= cnt + 2'd1;
            SRAM_A <= SRAM_A + ADDR_WIDTH'(1);
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          state     <= ST_IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          SRAM_CEN  <= 1'b1;
          SRAM_WEN  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed bench for ahb_sram_bridge with a negedge-sampled 8-bit SRAM model preloaded with addr ^ 0xA5.
module tb_ahb_sram_bridge;

  localparam int AW = 13;

  logic          clk;
  logic          hrstn;
  logic          hsel;
  logic [31:0]   haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [31:0]   hwdata;
  logic          hready;
  logic [31:0]   hrdata;
  logic          hreadyout;
  logic          hresp;
  logic          sram_cen;
  logic          sram_wen;
  logic [AW-1:0] sram_a;
  logic [7:0]    sram_d;
  logic [7:0]    sram_q;
  logic          sram_oen;

  logic [7:0] mem [0:(1<<AW)-1];
  int vec_cnt  = 0;
  int miss_cnt = 0;
  int cen_cnt  = 0;

  ahb_sram_bridge #(.ADDR_WIDTH(AW)) dut (
    .HCLK(clk), .HRESETn(hrstn), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HRDATA(hrdata), .HREADYOUT(hreadyout), .HRESP(hresp),
    .SRAM_CEN(sram_cen), .SRAM_WEN(sram_wen), .SRAM_A(sram_a), .SRAM_D(sram_d),
    .SRAM_Q(sram_q), .SRAM_OEN(sram_oen)
  );

  assign hready = hreadyout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i) ^ 8'hA5;
  end

  always @(negedge clk) begin
    if (!sram_cen) begin
      cen_cnt <= cen_cnt + 1;
      if (!sram_wen) mem[sram_a] <= sram_d;
      else           sram_q      <= mem[sram_a];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single transfer; entered and left at posedge+1 with the bridge idle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output int waits, output logic resp);
    hsel = 1'b1; htrans = 2'b10; haddr = addr; hwrite = wr; hsize = size;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hreadyout) break;
      waits++;
      @(posedge clk); #1;
    end
    rdata = hrdata;
    resp  = hresp;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        rsp;
  int          w;
  int          cen_before;

  initial begin
    hrstn = 1'b0; hsel = 1'b0; haddr = '0; htrans = 2'b00;
    hwrite = 1'b0; hsize = 3'd0; hwdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hreadyout", {31'd0, hreadyout}, 32'd1);
    check("rst_hresp",     {31'd0, hresp},     32'd0);
    check("rst_hrdata",    hrdata,             32'd0);
    check("rst_cen_wen",   {30'd0, sram_cen, sram_wen}, 32'd3);
    check("rst_sram_a",    {19'd0, sram_a},    32'd0);
    check("sram_oen",      {31'd0, sram_oen},  32'd0);
    hrstn = 1'b1;
    @(posedge clk); #1;

    // Word write then word read
    xfer(1'b1, 32'h0000_0010, 3'd2, 32'hA1B2_C3D4, rd, w, rsp);
    check("wr32_waits", w, 3);
    check("wr32_resp", {31'd0, rsp}, 32'd0);
    check("wr32_mem", {mem[19], mem[18], mem[17], mem[16]}, 32'hA1B2_C3D4);
    xfer(1'b0, 32'h0000_0010, 3'd2, 32'd0, rd, w, rsp);
    check("rd32_waits", w, 4);
    check("rd32_data", rd, 32'hA1B2_C3D4);

    // Byte write lane 3, halfword read upper half
    xfer(1'b1, 32'h0000_0013, 3'd0, 32'h5A00_0000, rd, w, rsp);
    check("wr8_waits", w, 0);
    check("wr8_mem", {24'd0, mem[19]}, 32'h0000_005A);
    xfer(1'b0, 32'h0000_0012, 3'd1, 32'd0, rd, w, rsp);
    check("rd16_waits", w, 2);
    check("rd16_data", rd, 32'h5AB2_0000);

    // Illegal transfers: misaligned word, oversized
    cen_before = cen_cnt;
    xfer(1'b0, 32'h0000_0002, 3'd2, 32'd0, rd, w, rsp);
    check("err_mis_resp", {31'd0, rsp}, 32'd1);
    check("err_mis_waits", w, 1);
    xfer(1'b1, 32'h0000_0000, 3'd3, 32'hFFFF_FFFF, rd, w, rsp);
    check("err_size_resp", {31'd0, rsp}, 32'd1);
    check("err_no_cen", cen_cnt - cen_before, 0);
    xfer(1'b0, 32'h0000_0010, 3'd2, 32'd0, rd, w, rsp);
    check("post_err_resp", {31'd0, rsp}, 32'd0);
    check("post_err_data", rd, 32'h5AB2_C3D4);

    // Back-to-back byte write then byte read at 0x0001
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h1; hwrite = 1'b1; hsize = 3'd0;
    @(posedge clk); #1;
    hwdata = 32'h0000_7700; hwrite = 1'b0;
    @(negedge clk);
    check("b2b_wr_cycle", {30'd0, sram_cen, sram_wen}, 32'd0);
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    check("b2b_rd_cycle", {30'd0, sram_cen, sram_wen}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_rdone", {31'd0, hreadyout}, 32'd1);
    check("b2b_data", hrdata, 32'h0000_7700);
    @(posedge clk); #1;

    // Reset during 2nd byte of a word read
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h20; hwrite = 1'b0; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(posedge clk); #2;
    hrstn = 1'b0;
    #1;
    check("mid_rst_ready", {31'd0, hreadyout}, 32'd1);
    check("mid_rst_hrdata", hrdata, 32'd0);
    check("mid_rst_cen", {30'd0, sram_cen, sram_wen}, 32'd3);
    @(posedge clk); #1;
    hrstn = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h0000_0020, 3'd2, 32'd0, rd, w, rsp);
    check("rd_after_rst", rd, 32'h8687_8485);

    // Reset during 2nd byte of a word write: only byte 0 lands
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h30; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1122_3344;
    @(posedge clk); #2;
    hrstn = 1'b0;
    @(posedge clk); #1;
    hrstn = 1'b1;
    @(posedge clk); #1;
    xfer(1'b0, 32'h0000_0030, 3'd2, 32'd0, rd, w, rsp);
    check("wr_abort_data", rd, 32'h9697_9444);

    // Upper address bits alias onto the SRAM
    xfer(1'b0, 32'hFFFF_E010, 3'd2, 32'd0, rd, w, rsp);
    check("alias_data", rd, 32'h5AB2_C3D4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
